// File: rtl/sik_pkg.sv
// Shared definitions for the SIK stack engine.
// Stack op codes, word widths and engine state encodings.
package sik_pkg;

  localparam int WORD     = 16;
  localparam int HALFWORD = 8;

  localparam logic [3:0] SOP_NOP   = 4'd0;
  localparam logic [3:0] SOP_PUSH  = 4'd1;
  localparam logic [3:0] SOP_POP   = 4'd2;
  localparam logic [3:0] SOP_GET   = 4'd3;
  localparam logic [3:0] SOP_PUT   = 4'd4;
  localparam logic [3:0] SOP_DUP   = 4'd5;
  localparam logic [3:0] SOP_REPL1 = 4'd6;
  localparam logic [3:0] SOP_REPL2 = 4'd7;
  localparam logic [3:0] SOP_CLRT  = 4'd8;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  function automatic int tid_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sik_stack_bank.sv
// One thread's operand stack storage.
// Single write port, three combinational read ports.
module sik_stack_bank
  import sik_pkg::*;
#(
  parameter int WIDTH = WORD,
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    addr_t,
  input  logic [AW-1:0]    addr_n,
  input  logic [AW-1:0]    addr_i,
  output logic [WIDTH-1:0] rd_t,
  output logic [WIDTH-1:0] rd_n,
  output logic [WIDTH-1:0] rd_i
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rd_t = mem[addr_t];
  assign rd_n = mem[addr_n];
  assign rd_i = mem[addr_i];

endmodule

// File: rtl/sik_stack_engine.sv
// Per-thread operand stack engine: banked storage, depth counters,
// sticky faults and a registered post-commit top/next response.
module sik_stack_engine
  import sik_pkg::*;
#(
  parameter int WIDTH    = WORD,
  parameter int DEPTH    = 256,
  parameter int NTHREADS = 2,
  parameter int IMM_W    = 12,
  localparam int TID_W = tid_width(NTHREADS),
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                op_valid,
  output logic                op_ready,
  input  logic [TID_W-1:0]    op_tid,
  input  logic [3:0]          op_code,
  input  logic [IMM_W-1:0]    op_imm,
  input  logic [WIDTH-1:0]    op_wdata,
  output logic                rsp_valid,
  output logic [TID_W-1:0]    rsp_tid,
  output logic [WIDTH-1:0]    rsp_top,
  output logic [WIDTH-1:0]    rsp_next,
  output logic [CW-1:0]       rsp_depth,
  output logic                rsp_err,
  output logic [NTHREADS-1:0] fault
);

  localparam int XW = ((IMM_W > CW) ? IMM_W : CW) + 1;

  logic [0:0]       state;
  logic [AW-1:0]    row;
  logic [CW-1:0]    cnt [NTHREADS];
  logic             fire;
  logic             tid_ok;
  logic             bad;
  logic [CW-1:0]    cur;
  logic [XW-1:0]    cx;
  logic [XW-1:0]    ix;
  logic [AW-1:0]    a_t;
  logic [AW-1:0]    a_n;
  logic [AW-1:0]    a_i;
  logic [WIDTH-1:0] bt [NTHREADS];
  logic [WIDTH-1:0] bn [NTHREADS];
  logic [WIDTH-1:0] bi [NTHREADS];
  logic [WIDTH-1:0] rt;
  logic [WIDTH-1:0] rn;
  logic [WIDTH-1:0] ri;
  logic             wen;
  logic [AW-1:0]    wa;
  logic [WIDTH-1:0] wd;
  logic [CW-1:0]    ndep;
  logic [WIDTH-1:0] ntop;
  logic [WIDTH-1:0] nnext;

  assign op_ready = (state == ST_RUN);
  assign fire     = op_valid && op_ready;
  assign tid_ok   = {1'b0, op_tid} < (TID_W+1)'(NTHREADS);
  assign cur      = tid_ok ? cnt[op_tid] : '0;
  assign cx       = XW'(cur);
  assign ix       = XW'(op_imm);

  always_comb begin
    bad = 1'b0;
    unique case (1'b1)
      (op_code == SOP_NOP):   bad = 1'b0;
      (op_code == SOP_PUSH):  bad = (cur == CW'(DEPTH));
      (op_code == SOP_POP):   bad = (ix > cx);
      (op_code == SOP_GET):   bad = (cur == CW'(DEPTH)) || (ix >= cx);
      (op_code == SOP_PUT):   bad = (ix >= cx);
      (op_code == SOP_DUP):   bad = (cur == CW'(DEPTH)) || (cur == '0);
      (op_code == SOP_REPL1): bad = (cur == '0);
      (op_code == SOP_REPL2): bad = (cur < CW'(2));
      (op_code == SOP_CLRT):  bad = 1'b0;
      default:                bad = 1'b1;
    endcase
    if (!tid_ok) bad = 1'b1;
  end

  // Port n is steered to whatever becomes the new next entry after the op.
  assign a_t = AW'(cx - XW'(1));
  assign a_i = AW'(cx - XW'(1) - ix);
  always_comb begin
    a_n = AW'(cx - XW'(2));
    if (!bad && op_code == SOP_POP)   a_n = AW'(cx - XW'(2) - ix);
    if (!bad && op_code == SOP_REPL2) a_n = AW'(cx - XW'(3));
  end

  assign rt = tid_ok ? bt[op_tid] : '0;
  assign rn = tid_ok ? bn[op_tid] : '0;
  assign ri = tid_ok ? bi[op_tid] : '0;

  always_comb begin
    wen   = 1'b0;
    wa    = a_t;
    wd    = op_wdata;
    ndep  = cur;
    ntop  = rt;
    nnext = rn;
    unique case (1'b1)
      (op_code == SOP_PUSH): begin
        wen   = 1'b1;
        wa    = AW'(cur);
        ndep  = cur + CW'(1);
        ntop  = op_wdata;
        nnext = rt;
      end
      (op_code == SOP_POP): begin
        ndep = cur - CW'(op_imm);
        ntop = ri;
      end
      (op_code == SOP_GET): begin
        wen   = 1'b1;
        wa    = AW'(cur);
        wd    = ri;
        ndep  = cur + CW'(1);
        ntop  = ri;
        nnext = rt;
      end
      (op_code == SOP_PUT): begin
        wen   = 1'b1;
        wa    = a_i;
        wd    = rt;
        nnext = (ix == XW'(1)) ? rt : rn;
      end
      (op_code == SOP_DUP): begin
        wen   = 1'b1;
        wa    = AW'(cur);
        wd    = rt;
        ndep  = cur + CW'(1);
        nnext = rt;
      end
      (op_code == SOP_REPL1): begin
        wen  = 1'b1;
        ntop = op_wdata;
      end
      (op_code == SOP_REPL2): begin
        wen  = 1'b1;
        wa   = AW'(cx - XW'(2));
        ndep = cur - CW'(1);
        ntop = op_wdata;
      end
      (op_code == SOP_CLRT): ndep = '0;
      default: ndep = cur;
    endcase
    if (bad) begin
      wen   = 1'b0;
      ndep  = cur;
      ntop  = rt;
      nnext = rn;
    end
  end

  for (genvar g = 0; g < NTHREADS; g++) begin : g_bank
    logic           we_g;
    logic [AW-1:0]  wa_g;
    logic [WIDTH-1:0] wd_g;
    assign we_g = !reset && ((state == ST_INIT) ||
                  (fire && wen && op_tid == TID_W'(g)));
    assign wa_g = (state == ST_INIT) ? row : wa;
    assign wd_g = (state == ST_INIT) ? '0 : wd;
    sik_stack_bank #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
    ) u_bank (
      .clk   (clk),
      .we    (we_g),
      .waddr (wa_g),
      .wdata (wd_g),
      .addr_t(a_t),
      .addr_n(a_n),
      .addr_i(a_i),
      .rd_t  (bt[g]),
      .rd_n  (bn[g]),
      .rd_i  (bi[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_INIT;
      row       <= '0;
      rsp_valid <= 1'b0;
      rsp_tid   <= '0;
      rsp_top   <= '0;
      rsp_next  <= '0;
      rsp_depth <= '0;
      rsp_err   <= 1'b0;
      fault     <= '0;
      for (int i = 0; i < NTHREADS; i++) cnt[i] <= '0;
    end else begin
      rsp_valid <= fire;
      if (state == ST_INIT) begin
        row <= row + AW'(1);
        if (row == AW'(DEPTH - 1)) state <= ST_RUN;
      end
      if (fire) begin
        rsp_tid   <= op_tid;
        rsp_top   <= (ndep == '0) ? '0 : ntop;
        rsp_next  <= (ndep < CW'(2)) ? '0 : nnext;
        rsp_depth <= ndep;
        rsp_err   <= bad;
        if (tid_ok) begin
          if (bad) begin
            fault[op_tid] <= 1'b1;
          end else begin
            cnt[op_tid] <= ndep;
            if (op_code == SOP_CLRT) fault[op_tid] <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sik_stack_engine.sv
// Directed bench for sik_stack_engine: vector table plus
// init sweep, overflow and mid-stream reset sequences.
module tb_sik_stack_engine;
  import sik_pkg::*;

  localparam int WIDTH = 16;
  localparam int DEPTH = 256;
  localparam int NT    = 2;
  localparam int IMM_W = 12;
  localparam int TID_W = 1;
  localparam int CW    = 9;

  logic             clk;
  logic             reset;
  logic             op_valid;
  logic             op_ready;
  logic [TID_W-1:0] op_tid;
  logic [3:0]       op_code;
  logic [IMM_W-1:0] op_imm;
  logic [WIDTH-1:0] op_wdata;
  logic             rsp_valid;
  logic [TID_W-1:0] rsp_tid;
  logic [WIDTH-1:0] rsp_top;
  logic [WIDTH-1:0] rsp_next;
  logic [CW-1:0]    rsp_depth;
  logic             rsp_err;
  logic [NT-1:0]    fault;

  sik_stack_engine #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .NTHREADS(NT),
    .IMM_W(IMM_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .op_tid   (op_tid),
    .op_code  (op_code),
    .op_imm   (op_imm),
    .op_wdata (op_wdata),
    .rsp_valid(rsp_valid),
    .rsp_tid  (rsp_tid),
    .rsp_top  (rsp_top),
    .rsp_next (rsp_next),
    .rsp_depth(rsp_depth),
    .rsp_err  (rsp_err),
    .fault    (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [TID_W-1:0] tid;
    logic [3:0]       code;
    logic [IMM_W-1:0] imm;
    logic [WIDTH-1:0] wd;
    logic             err;
    logic [WIDTH-1:0] top;
    logic [WIDTH-1:0] nxt;
    logic [CW-1:0]    dep;
    logic [NT-1:0]    flt;
  } vec_t;

  vec_t tbl[$];
  int   pass_n;
  int   total_n;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic void v(input int tid, input logic [3:0] code,
                            input int imm, input int wd, input int err,
                            input int top, input int nxt, input int dep,
                            input int flt);
    vec_t e;
    e.tid  = TID_W'(tid);
    e.code = code;
    e.imm  = IMM_W'(imm);
    e.wd   = WIDTH'(wd);
    e.err  = 1'(err);
    e.top  = WIDTH'(top);
    e.nxt  = WIDTH'(nxt);
    e.dep  = CW'(dep);
    e.flt  = NT'(flt);
    tbl.push_back(e);
  endfunction

  task automatic op(input int tid, input logic [3:0] code,
                    input int imm, input int wd);
    @(negedge clk);
    op_valid = 1'b1;
    op_tid   = TID_W'(tid);
    op_code  = code;
    op_imm   = IMM_W'(imm);
    op_wdata = WIDTH'(wd);
    @(posedge clk);
    #1;
    op_valid = 1'b0;
  endtask

  task automatic rsp(input string nm, input int err, input int top,
                     input int nxt, input int dep);
    chk({nm, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({nm, "_err"}, 32'(rsp_err), 32'(err));
    chk({nm, "_top"}, 32'(rsp_top), 32'(top));
    chk({nm, "_next"}, 32'(rsp_next), 32'(nxt));
    chk({nm, "_depth"}, 32'(rsp_depth), 32'(dep));
  endtask

  task automatic sweep(input string nm);
    int n;
    int noisy;
    n = 0;
    noisy = 0;
    while (!op_ready && n < DEPTH + 20) begin
      @(posedge clk);
      #1;
      n++;
      if (rsp_valid || fault != '0) noisy++;
    end
    chk({nm, "_len"}, 32'(n), 32'(DEPTH));
    chk({nm, "_quiet"}, 32'(noisy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int errs;
    pass_n   = 0;
    total_n  = 0;
    reset    = 1'b1;
    op_valid = 1'b0;
    op_tid   = '0;
    op_code  = SOP_NOP;
    op_imm   = '0;
    op_wdata = '0;

    v(0, SOP_PUSH,  0,     5,  0,  5, 0, 1, 0);
    v(0, SOP_PUSH,  0,     7,  0,  7, 5, 2, 0);
    v(0, SOP_NOP,   0,     0,  0,  7, 5, 2, 0);
    v(0, SOP_REPL2, 0,    12,  0, 12, 0, 1, 0);
    v(0, SOP_REPL1, 0,     1,  0,  1, 0, 1, 0);
    v(0, SOP_PUSH,  0,     2,  0,  2, 1, 2, 0);
    v(0, SOP_PUSH,  0,     3,  0,  3, 2, 3, 0);
    v(0, SOP_GET,   2,     0,  0,  1, 3, 4, 0);
    v(0, SOP_PUT,   3,     0,  0,  1, 3, 4, 0);
    v(0, SOP_POP,   1,     0,  0,  3, 2, 3, 0);
    v(0, SOP_POP,   1,     0,  0,  2, 1, 2, 0);
    v(0, SOP_POP,   1,     0,  0,  1, 0, 1, 0);
    v(1, SOP_PUSH,  0,     9,  0,  9, 0, 1, 0);
    v(1, SOP_DUP,   0,     0,  0,  9, 9, 2, 0);
    v(1, SOP_REPL1, 0,     4,  0,  4, 9, 2, 0);
    v(1, SOP_PUT,   1,     0,  0,  4, 4, 2, 0);
    v(0, SOP_GET,   1,     0,  1,  1, 0, 1, 1);
    v(0, SOP_POP,   1,     0,  0,  0, 0, 0, 1);
    v(0, SOP_POP,   1,     0,  1,  0, 0, 0, 1);
    v(0, SOP_POP,   0,     0,  0,  0, 0, 0, 1);
    v(0, 4'hF,      0,     0,  1,  0, 0, 0, 1);
    v(0, SOP_DUP,   0,     0,  1,  0, 0, 0, 1);
    v(0, SOP_REPL2, 0,     0,  1,  0, 0, 0, 1);
    v(1, SOP_POP,   2,     0,  0,  0, 0, 0, 1);
    v(0, SOP_CLRT,  0,     0,  0,  0, 0, 0, 0);
    v(1, SOP_PUSH,  0, 'h55,   0, 'h55, 0, 1, 0);
    v(1, SOP_POP,   2,     0,  1, 'h55, 0, 1, 2);
    v(0, SOP_PUSH,  0,     3,  0,  3, 0, 1, 2);
    v(0, SOP_POP,  'h101,  0,  1,  3, 0, 1, 3);
    v(0, SOP_CLRT,  0,     0,  0,  0, 0, 0, 2);
    v(1, SOP_CLRT,  0,     0,  0,  0, 0, 0, 0);

    @(posedge clk);
    #1;
    chk("rst_ready", 32'(op_ready), 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_depth", 32'(rsp_depth), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    sweep("init");

    foreach (tbl[i]) begin
      op(tbl[i].tid, tbl[i].code, tbl[i].imm, tbl[i].wd);
      rsp($sformatf("v%0d", i), tbl[i].err, tbl[i].top,
          tbl[i].nxt, tbl[i].dep);
      chk($sformatf("v%0d_tid", i), 32'(rsp_tid), 32'(tbl[i].tid));
      chk($sformatf("v%0d_fault", i), 32'(fault), 32'(tbl[i].flt));
    end

    op(0, SOP_PUSH, 0, 'hAA);
    rsp("t0_mark", 0, 'hAA, 0, 1);
    errs = 0;
    for (int i = 0; i < DEPTH; i++) begin
      op(1, SOP_PUSH, 0, i + 1);
      if (rsp_err || rsp_depth != CW'(i + 1)) errs++;
    end
    chk("fill_errs", 32'(errs), 32'd0);
    op(1, SOP_PUSH, 0, 'hBEEF);
    rsp("ovf", 1, DEPTH, DEPTH - 1, DEPTH);
    chk("ovf_fault", 32'(fault), 32'd2);
    op(0, SOP_NOP, 0, 0);
    rsp("t0_intact", 0, 'hAA, 0, 1);
    op(1, SOP_CLRT, 0, 0);
    rsp("clrt1", 0, 0, 0, 0);
    chk("clrt1_fault", 32'(fault), 32'd0);

    op(1, SOP_POP, 5, 0);
    chk("pre_rst_fault", 32'(fault), 32'd2);
    for (int i = 0; i < 6; i++) begin
      op(i % 2, SOP_PUSH, 0, 100 + i);
      chk($sformatf("il%0d_depth", i), 32'(rsp_depth),
          32'(i / 2 + 1 + ((i % 2 == 0) ? 1 : 0)));
    end
    @(negedge clk);
    op_valid = 1'b1;
    op_tid   = '0;
    op_code  = SOP_PUSH;
    op_wdata = 16'h1234;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_ready", 32'(op_ready), 32'd0);
    chk("mid_rst_fault", 32'(fault), 32'd0);
    @(negedge clk);
    reset    = 1'b0;
    op_valid = 1'b0;
    sweep("reinit");
    op(0, SOP_NOP, 0, 0);
    rsp("post_t0", 0, 0, 0, 0);
    op(1, SOP_NOP, 0, 0);
    rsp("post_t1", 0, 0, 0, 0);
    chk("post_fault", 32'(fault), 32'd0);

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
